// File: rtl/p2s_slave_pkg.sv
// p2s_slave_pkg
//   Shared helpers for the p2s_slave slice.
//   clogb2(value): number of bits needed to encode 0 .. value-1.
package p2s_slave_pkg;

    function automatic int unsigned clogb2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/p2s_slave_filter.sv
// sig_filter
//   Conditions one asynchronous pin: 2-FF synchroniser, then a glitch filter
//   that only changes its output after FILT_LEN consecutive equal samples
//   that differ from the current output, then 1-clk edge pulses.
// Ports
//   clk   in   system clock
//   rst   in   asynchronous active-high reset (all stages reset to RST_VAL)
//   din   in   raw pin
//   q     out  filtered level
//   rise  out  1-clk pulse on filtered 0->1
//   fall  out  1-clk pulse on filtered 1->0
module sig_filter
    import p2s_slave_pkg::*;
#(
    parameter int unsigned FILT_LEN = 3,
    parameter logic        RST_VAL  = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic q,
    output logic rise,
    output logic fall
);

    localparam int unsigned CW = clogb2(FILT_LEN + 1);

    logic          s1;
    logic          s2;
    logic          prev;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1   <= RST_VAL;
            s2   <= RST_VAL;
            q    <= RST_VAL;
            prev <= RST_VAL;
            cnt  <= '0;
        end else begin
            s1   <= din;
            s2   <= s1;
            prev <= q;
            // cnt counts consecutive samples disagreeing with q; the
            // FILT_LEN-th such sample is taken as the new level.
            if (s2 == q) begin
                cnt <= '0;
            end else if (cnt == CW'(FILT_LEN - 1)) begin
                q   <= s2;
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign rise = q & ~prev;
    assign fall = ~q & prev;

endmodule

// File: rtl/p2s_slave.sv
// p2s_slave
//   Far-side 74HC165-style load/shift register driven by a master's
//   sld_n/sclk, oversampled in the local clk domain. Loads pi while the
//   filtered sld_n is low, shifts one bit (LSB first) per filtered sclk fall,
//   and reports frame completion / framing errors at each sld_n fall.
// Ports
//   clk         in   system clock
//   rst         in   asynchronous active-high reset
//   pi          in   NBIT parallel data, bit 0 shifted out first
//   sclk        in   serial clock from master (async)
//   sld_n       in   active-low load strobe from master (async)
//   so          out  serial data (sr[0], registered)
//   frame_done  out  1-clk pulse: previous frame shifted exactly NBIT-1 times
//   frame_err   out  sticky framing error
//   err_clr     in   synchronous clear of frame_err (an error in the same clk wins)
module p2s_slave
    import p2s_slave_pkg::*;
#(
    parameter int unsigned NBIT     = 64,
    parameter int unsigned FILT_LEN = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NBIT-1:0] pi,
    input  logic            sclk,
    input  logic            sld_n,
    output logic            so,
    output logic            frame_done,
    output logic            frame_err,
    input  logic            err_clr
);

    localparam int unsigned    WBC  = clogb2(NBIT + 1);
    localparam logic [WBC-1:0] LAST = WBC'(NBIT - 1);
    localparam logic [WBC-1:0] FULL = WBC'(NBIT);

    logic            sclk_lvl_unused;
    logic            sclk_rise_unused;
    logic            sclk_fall;
    logic            sld_lvl;
    logic            sld_rise;
    logic            sld_fall;

    logic [NBIT-1:0] sr;
    logic [WBC-1:0]  bit_cnt;
    logic            armed;
    logic            err_set;

    sig_filter #(
        .FILT_LEN (FILT_LEN),
        .RST_VAL  (1'b0)
    ) u_sclk_filt (
        .clk  (clk),
        .rst  (rst),
        .din  (sclk),
        .q    (sclk_lvl_unused),
        .rise (sclk_rise_unused),
        .fall (sclk_fall)
    );

    sig_filter #(
        .FILT_LEN (FILT_LEN),
        .RST_VAL  (1'b1)
    ) u_sld_filt (
        .clk  (clk),
        .rst  (rst),
        .din  (sld_n),
        .q    (sld_lvl),
        .rise (sld_rise),
        .fall (sld_fall)
    );

    // The master's last sclk fall lands together with sld_n fall; the load
    // branch takes priority so that fall never reaches the counter, and the
    // frame check sees the pre-load bit_cnt in the sld_fall cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr      <= '0;
            bit_cnt <= '0;
        end else if (!sld_lvl) begin
            sr      <= pi;
            bit_cnt <= '0;
        end else if (sclk_fall) begin
            sr <= {1'b0, sr[NBIT-1:1]};
            if (bit_cnt != FULL) begin
                bit_cnt <= bit_cnt + 1'b1;
            end
        end
    end

    assign err_set = sld_fall & armed & (bit_cnt != LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            armed      <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            if (sld_rise) begin
                armed <= 1'b1;
            end
            frame_done <= sld_fall & armed & (bit_cnt == LAST);
            if (err_set) begin
                frame_err <= 1'b1;
            end else if (err_clr) begin
                frame_err <= 1'b0;
            end
        end
    end

    assign so = sr[0];

endmodule

// File: tb/tb_p2s_slave.sv
module tb_p2s_slave;

    localparam int unsigned NBIT     = 8;
    localparam int unsigned FILT_LEN = 3;
    localparam int unsigned TICK     = 20;

    logic            clk = 1'b0;
    logic            rst;
    logic [NBIT-1:0] pi;
    logic            sclk;
    logic            sld_n;
    logic            so;
    logic            frame_done;
    logic            frame_err;
    logic            err_clr;

    int tests    = 0;
    int fails    = 0;
    int done_cnt = 0;

    // Behavioural model: the word captured when sld_n is released, how many
    // counted sclk falls happened since, whether a frame is being judged.
    logic [NBIT-1:0] m_loaded;
    logic [NBIT-1:0] po;
    bit              m_armed;
    bit              m_err;
    int              m_falls;

    p2s_slave #(
        .NBIT     (NBIT),
        .FILT_LEN (FILT_LEN)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pi         (pi),
        .sclk       (sclk),
        .sld_n      (sld_n),
        .so         (so),
        .frame_done (frame_done),
        .frame_err  (frame_err),
        .err_clr    (err_clr)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_done === 1'b1) done_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic exp_so();
        logic [NBIT-1:0] w;
        w = m_loaded;
        if (m_falls < int'(NBIT)) return w[m_falls];
        return 1'b0;
    endfunction

    function automatic int exp_cnt();
        return (m_falls > int'(NBIT)) ? int'(NBIT) : m_falls;
    endfunction

    task automatic do_reset(input string tag);
        rst = 1'b1;
        wait_clk(3);
        chk({tag, "_so"},    32'(so),          32'd0);
        chk({tag, "_done"},  32'(frame_done),  32'd0);
        chk({tag, "_err"},   32'(frame_err),   32'd0);
        chk({tag, "_cnt"},   32'(dut.bit_cnt), 32'd0);
        chk({tag, "_armed"}, 32'(dut.armed),   32'd0);
        rst = 1'b0;
        m_armed = 1'b0;
        m_err   = 1'b0;
        m_falls = 0;
        wait_clk(TICK);
    endtask

    // sclk rises, master samples so at the end of the high phase, then pi is
    // scrambled: a change while shifting must not reach so.
    task automatic rise_sample(input string tag);
        sclk = 1'b1;
        wait_clk(TICK);
        chk(tag, 32'(so), 32'(exp_so()));
        if (m_falls < int'(NBIT)) po[m_falls] = so;
        pi = NBIT'($urandom);
    endtask

    task automatic fall_shift();
        sclk = 1'b0;
        m_falls++;
        wait_clk(TICK);
    endtask

    // Final sclk fall coincident with sld_n fall; judge the finished frame.
    task automatic frame_end(input string tag, input bit clr_same);
        bit exp_done;
        int d0;
        chk({tag, "_cnt_pre"}, 32'(dut.bit_cnt), 32'(exp_cnt()));
        exp_done = m_armed && (m_falls == int'(NBIT) - 1);
        if (m_armed && !exp_done) m_err = 1'b1;
        d0 = done_cnt;
        sclk  = 1'b0;
        sld_n = 1'b0;
        if (clr_same) begin
            wait_clk(2 + FILT_LEN);
            err_clr = 1'b1;
            wait_clk(1);
            err_clr = 1'b0;
            wait_clk(TICK - 3 - FILT_LEN);
        end else begin
            wait_clk(TICK);
        end
        chk({tag, "_done"},     32'(done_cnt - d0),  32'(exp_done));
        chk({tag, "_err"},      32'(frame_err),      32'(m_err));
        chk({tag, "_cnt_load"}, 32'(dut.bit_cnt),    32'd0);
        m_falls = 0;
    endtask

    task automatic release_ld();
        sld_n    = 1'b1;
        m_loaded = pi;
        m_armed  = 1'b1;
        m_falls  = 0;
        po       = '0;
        wait_clk(TICK);
    endtask

    task automatic run_frame(input string tag, input int total_falls, input bit clr_same);
        while (m_falls < total_falls) begin
            rise_sample({tag, "_so"});
            fall_shift();
        end
        rise_sample({tag, "_so_last"});
        frame_end(tag, clr_same);
    endtask

    task automatic clear_err(input string tag);
        err_clr = 1'b1;
        wait_clk(1);
        err_clr = 1'b0;
        wait_clk(1);
        m_err = 1'b0;
        chk(tag, 32'(frame_err), 32'd0);
    endtask

    task automatic pulse_sclk(input string tag, input int unsigned width, input bit counts);
        sclk = 1'b1;
        wait_clk(width);
        sclk = 1'b0;
        if (counts) m_falls++;
        wait_clk(TICK);
        chk({tag, "_cnt"}, 32'(dut.bit_cnt), 32'(exp_cnt()));
        chk({tag, "_so"},  32'(so),          32'(exp_so()));
    endtask

    initial begin
        rst     = 1'b1;
        sclk    = 1'b0;
        sld_n   = 1'b1;
        err_clr = 1'b0;
        pi      = '0;
        m_loaded = '0;
        po       = '0;
        m_armed  = 1'b0;
        m_err    = 1'b0;
        m_falls  = 0;

        do_reset("reset");

        // 1: first load is unarmed, then two full frames
        pi = 8'hA5;
        frame_end("t1_first", 1'b0);
        release_ld();
        run_frame("t1_f1", NBIT - 1, 1'b0);
        chk("t1_po", 32'(po), 32'h0000_00A5);
        pi = NBIT'($urandom);
        wait_clk(TICK);
        release_ld();
        run_frame("t1_f2", NBIT - 1, 1'b0);
        chk("t1_po2", 32'(po), 32'(m_loaded));

        // 2: pi changes while loading are tracked
        pi = 8'hA5;
        wait_clk(TICK);
        pi = 8'h3C;
        wait_clk(TICK);
        release_ld();
        run_frame("t2", NBIT - 1, 1'b0);
        chk("t2_po", 32'(po), 32'h0000_003C);

        // 3: sclk glitches
        pi = NBIT'($urandom);
        release_ld();
        pulse_sclk("t3_g1", 1, 1'b0);
        pulse_sclk("t3_g2", 2, 1'b0);
        pulse_sclk("t3_p3", 3, 1'b1);
        run_frame("t3", NBIT - 1, 1'b0);

        // 4: truncated frames, clear, clear colliding with a new error
        release_ld();
        run_frame("t4_trunc", 5, 1'b0);
        clear_err("t4_clr");
        release_ld();
        run_frame("t4_coll", 3, 1'b1);

        // 5: overlong frame saturates the counter and shifts out zeros
        clear_err("t5_clr");
        release_ld();
        run_frame("t5_long", 10, 1'b0);

        // 6: reset mid-frame, then a load before any sld_n rise
        clear_err("t6_clr");
        release_ld();
        repeat (4) begin
            rise_sample("t6_so");
            fall_shift();
        end
        chk("t6_cnt4", 32'(dut.bit_cnt), 32'd4);
        do_reset("t6_rst");
        frame_end("t6_unarmed", 1'b0);
        release_ld();
        run_frame("t6_after", NBIT - 1, 1'b0);

        // randomised frame lengths and data
        for (int k = 0; k < 8; k++) begin
            pi = NBIT'($urandom);
            wait_clk(TICK);
            release_ld();
            run_frame("rnd", int'($urandom_range(0, 10)), 1'b0);
            if (m_err) clear_err("rnd_clr");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
